// File: rtl/barrel_shift_seq_if.sv
// rtl/barrel_shift_seq_if.sv - command/result handshake bundle for the sequential barrel shifter
interface barrel_shift_seq_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   amt;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             busy;

    modport master (
        output in_valid, din, amt, mode, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, din, amt, mode, out_ready,
        output in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/barrel_shift_seq.sv
// rtl/barrel_shift_seq.sv - barrel shifter reusing one 2^k stage for log2(WIDTH) cycles
module barrel_shift_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    barrel_shift_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_stage;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] dout_r;
    logic [SHW-1:0]   k;
    logic [SHW-1:0]   amt_r;
    logic [SHW-1:0]   sh;
    logic [SHW:0]     rsh;
    logic [1:0]       mode_r;
    logic             last_stage;

    assign last_stage = (k == K_LAST);

    // Shared stage: shift by 2^k, applied only when the matching amount bit is set.
    always_comb begin
        sh      = SHW'(1) << k;
        rsh     = (SHW+1)'(WIDTH) - {1'b0, sh};
        shifted = acc;
        case (mode_r)
            2'b00:   shifted = acc << sh;
            2'b01:   shifted = acc >> sh;
            2'b10:   shifted = $signed(acc) >>> sh;
            default: shifted = (acc >> sh) | (acc << rsh);
        endcase
        acc_stage = amt_r[k] ? shifted : acc;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = SHIFT;
            SHIFT:   if (last_stage)    state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // dout_r is a separate register so the result stays put while the next command shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            dout_r <= '0;
            k      <= '0;
            amt_r  <= '0;
            mode_r <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc    <= bus.din;
                        amt_r  <= bus.amt;
                        mode_r <= bus.mode;
                        k      <= '0;
                    end
                end
                SHIFT: begin
                    acc <= acc_stage;
                    k   <= k + 1'b1;
                    if (last_stage) begin
                        dout_r <= acc_stage;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.dout      = dout_r;
endmodule

// File: tb/tb_barrel_shift_seq.sv
// tb/tb_barrel_shift_seq.sv - scoreboard bench for barrel_shift_seq
module tb_barrel_shift_seq;
    logic clk;
    logic rst_n;
    int   cyc;
    int   accept_cyc;
    int   vectors;
    int   miscompares;
    int   pushed;
    int   popped;
    int   rdy_mode;
    bit   prev_ov;
    logic [7:0] exp_q[$];

    barrel_shift_seq_if #(.WIDTH(8)) bus ();

    barrel_shift_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = $signed(d) >>> a;
            default: r = (d >> a) | (d << (4'd8 - {1'b0, a}));
        endcase
        return r;
    endfunction

    // Monitor: latency on every out_valid rise, and pop/compare at each result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                check("latency", cyc - accept_cyc, 3);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no result", bus.dout);
                end else begin
                    check("dout", bus.dout, exp_q.pop_front());
                    popped++;
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                        input logic [7:0] e, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready 0, expected 1 within 200 cycles");
            return;
        end
        bus.in_valid = 1'b1;
        bus.din      = d;
        bus.amt      = a;
        bus.mode     = m;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (track) begin
            exp_q.push_back(e);
            pushed++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] m;
        logic [7:0] e;
    } vec_t;

    vec_t dir_vecs[9] = '{
        '{8'hB3, 3'd3, 2'b00, 8'h98},
        '{8'hB3, 3'd3, 2'b01, 8'h16},
        '{8'hB3, 3'd3, 2'b10, 8'hF6},
        '{8'hB3, 3'd3, 2'b11, 8'h76},
        '{8'h4D, 3'd3, 2'b10, 8'h09},
        '{8'hA5, 3'd0, 2'b01, 8'hA5},
        '{8'hA5, 3'd0, 2'b11, 8'hA5},
        '{8'h81, 3'd7, 2'b11, 8'h03},
        '{8'h80, 3'd7, 2'b10, 8'hFF}
    };

    initial begin
        int n;
        cyc          = 0;
        accept_cyc   = 0;
        vectors      = 0;
        miscompares  = 0;
        pushed       = 0;
        popped       = 0;
        rdy_mode     = 1;
        prev_ov      = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.din      = '0;
        bus.amt      = '0;
        bus.mode     = 2'b00;

        repeat (3) @(negedge clk);
        check("reset_dout", bus.dout, 8'h00);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);

        foreach (dir_vecs[i]) begin
            send(dir_vecs[i].d, dir_vecs[i].a, dir_vecs[i].m, dir_vecs[i].e, 1'b1);
        end
        wait_drain();

        // Back-pressure with an ignored command presented during DONE.
        rdy_mode = 0;
        send(8'hB3, 3'd3, 2'b00, 8'h98, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", bus.out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_dout", bus.dout, 8'h98);
            check("bp_in_ready", bus.in_ready, 0);
            bus.in_valid = 1'b1;
            bus.din      = 8'hFF;
            bus.amt      = 3'd1;
            bus.mode     = 2'b00;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rdy_mode = 1;
        n = 0;
        while (bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_in_ready_after", bus.in_ready, 1);
        repeat (8) @(negedge clk);
        check("bp_ignored_cmd_idle", bus.busy, 0);

        // Reset during SHIFT must abort with no result.
        send(8'hB3, 3'd5, 2'b00, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_dout", bus.dout, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_no_valid", bus.out_valid, 0);

        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] d;
            logic [2:0] a;
            logic [1:0] m;
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            m = 2'($urandom_range(0, 3));
            send(d, a, m, model(d, a, m), 1'b1);
        end
        wait_drain();
        check("pushed_eq_popped", popped, pushed);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
